// File: rtl/riscv_bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Table geometry, counter encodings and the BTB entry layout.
package riscv_bp_pkg;

  localparam int INDEX_W = 6;
  localparam int TAG_W = 12;
  localparam int BP_ENTRIES = 2 ** INDEX_W;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  localparam logic [1:0] CNT_RST = WNT;

  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [63:0] target;
  } bp_entry_t;

endpackage

// File: rtl/riscv_bp_sat_counter.sv
// 2-bit saturating counter next-state function.
// Increments on taken, decrements on not-taken, clamps at SNT/ST.
module riscv_bp_sat_counter
  import riscv_bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      (inc && (cnt != ST)):  nxt = cnt + 2'd1;
      (!inc && (cnt != SNT)): nxt = cnt - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor for the IF stage.
// Define RISCV_BP_GSHARE_EN to XOR a global history into the counter index.
module riscv_branch_predictor
  import riscv_bp_pkg::*;
(
  input  logic        i_riscv_bp_clk,
  input  logic        i_riscv_bp_rst_n,
  input  logic [63:0] i_riscv_bp_pc_if,
  output logic        o_riscv_bp_hit,
  output logic        o_riscv_bp_predict_taken,
  output logic [63:0] o_riscv_bp_predict_target,
  input  logic        i_riscv_bp_upd_valid,
  input  logic [63:0] i_riscv_bp_upd_pc,
  input  logic        i_riscv_bp_upd_taken,
  input  logic [63:0] i_riscv_bp_upd_target,
  input  logic        i_riscv_bp_upd_pred_taken,
  input  logic [63:0] i_riscv_bp_upd_pred_target,
  output logic        o_riscv_bp_mispredict,
  output logic [31:0] o_riscv_bp_mispredict_cnt
);

  bp_entry_t tbl [BP_ENTRIES];
  logic [1:0] ctr [BP_ENTRIES];

  logic [INDEX_W-1:0] lk_idx;
  logic [INDEX_W-1:0] up_idx;
  logic [INDEX_W-1:0] lk_cidx;
  logic [INDEX_W-1:0] up_cidx;
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic [1:0]         ctr_nxt;
  logic [31:0]        mp_cnt;
  logic               unused_pc;

  assign lk_idx = i_riscv_bp_pc_if[INDEX_W:1];
  assign up_idx = i_riscv_bp_upd_pc[INDEX_W:1];
  assign lk_tag = i_riscv_bp_pc_if[INDEX_W+TAG_W:INDEX_W+1];
  assign up_tag = i_riscv_bp_upd_pc[INDEX_W+TAG_W:INDEX_W+1];

  assign unused_pc = ^{i_riscv_bp_pc_if[63:INDEX_W+TAG_W+1],
                       i_riscv_bp_pc_if[0],
                       i_riscv_bp_upd_pc[63:INDEX_W+TAG_W+1],
                       i_riscv_bp_upd_pc[0]};

`ifdef RISCV_BP_GSHARE_EN
  logic [INDEX_W-1:0] ghr;

  // History only advances on resolved branches, never speculatively.
  always_ff @(posedge i_riscv_bp_clk or negedge i_riscv_bp_rst_n) begin
    if (!i_riscv_bp_rst_n) begin
      ghr <= '0;
    end else if (i_riscv_bp_upd_valid) begin
      ghr <= {ghr[INDEX_W-2:0], i_riscv_bp_upd_taken};
    end
  end

  assign lk_cidx = lk_idx ^ ghr;
  assign up_cidx = up_idx ^ ghr;
`else
  assign lk_cidx = lk_idx;
  assign up_cidx = up_idx;
`endif

  assign o_riscv_bp_hit = tbl[lk_idx].valid && (tbl[lk_idx].tag == lk_tag);
  assign o_riscv_bp_predict_taken = o_riscv_bp_hit && ctr[lk_cidx][1];
  assign o_riscv_bp_predict_target =
    o_riscv_bp_hit ? tbl[lk_idx].target : 64'd0;

  assign up_hit = tbl[up_idx].valid && (tbl[up_idx].tag == up_tag);

  assign o_riscv_bp_mispredict = i_riscv_bp_upd_valid &&
    ((i_riscv_bp_upd_taken != i_riscv_bp_upd_pred_taken) ||
     (i_riscv_bp_upd_taken && i_riscv_bp_upd_pred_taken &&
      (i_riscv_bp_upd_target != i_riscv_bp_upd_pred_target)));

  riscv_bp_sat_counter u_sat (
    .cnt (ctr[up_cidx]),
    .inc (i_riscv_bp_upd_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge i_riscv_bp_clk or negedge i_riscv_bp_rst_n) begin
    if (!i_riscv_bp_rst_n) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        tbl[i] <= '0;
        ctr[i] <= CNT_RST;
      end
    end else if (i_riscv_bp_upd_valid) begin
      if (up_hit) begin
        ctr[up_cidx] <= ctr_nxt;
        if (i_riscv_bp_upd_taken) begin
          tbl[up_idx].target <= i_riscv_bp_upd_target;
        end
      end else if (i_riscv_bp_upd_taken) begin
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag,
                         target: i_riscv_bp_upd_target};
        ctr[up_cidx] <= WT;
      end
    end
  end

  always_ff @(posedge i_riscv_bp_clk or negedge i_riscv_bp_rst_n) begin
    if (!i_riscv_bp_rst_n) begin
      mp_cnt <= '0;
    end else if (o_riscv_bp_mispredict) begin
      mp_cnt <= mp_cnt + 32'd1;
    end
  end

  assign o_riscv_bp_mispredict_cnt = mp_cnt;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed bench for riscv_branch_predictor (default build).
// Inputs change on the falling edge; outputs are checked mid-cycle.
module tb_riscv_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc_if;
  logic        hit;
  logic        ptaken;
  logic [63:0] ptarget;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_pred_taken;
  logic [63:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] mp_cnt;

  int tests = 0;
  int fails = 0;

  riscv_branch_predictor dut (
    .i_riscv_bp_clk             (clk),
    .i_riscv_bp_rst_n           (rst_n),
    .i_riscv_bp_pc_if           (pc_if),
    .o_riscv_bp_hit             (hit),
    .o_riscv_bp_predict_taken   (ptaken),
    .o_riscv_bp_predict_target  (ptarget),
    .i_riscv_bp_upd_valid       (upd_valid),
    .i_riscv_bp_upd_pc          (upd_pc),
    .i_riscv_bp_upd_taken       (upd_taken),
    .i_riscv_bp_upd_target      (upd_target),
    .i_riscv_bp_upd_pred_taken  (upd_pred_taken),
    .i_riscv_bp_upd_pred_target (upd_pred_target),
    .o_riscv_bp_mispredict      (mispredict),
    .o_riscv_bp_mispredict_cnt  (mp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [63:0] pc, input logic eh,
                      input logic et, input logic [63:0] etgt,
                      input string tag);
    pc_if = pc;
    #1;
    chk({tag, ".hit"}, {63'd0, hit}, {63'd0, eh});
    chk({tag, ".taken"}, {63'd0, ptaken}, {63'd0, et});
    chk({tag, ".target"}, ptarget, etgt);
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk,
                     input logic [63:0] tgt, input logic ptk,
                     input logic [63:0] ptgt, input logic emp,
                     input string tag);
    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tgt;
    upd_pred_taken = ptk;
    upd_pred_target = ptgt;
    #1;
    chk({tag, ".mispredict"}, {63'd0, mispredict}, {63'd0, emp});
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic cnt_is(input logic [31:0] e, input string tag);
    chk({tag, ".cnt"}, {32'd0, mp_cnt}, {32'd0, e});
  endtask

  initial begin
    rst_n = 1'b0;
    pc_if = 64'h1000;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    #12;
    look(64'h1000, 1'b0, 1'b0, 64'h0, "rst");
    cnt_is(32'd0, "rst");
    chk("rst.mispredict", {63'd0, mispredict}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    upd(64'h1000, 1'b1, 64'h1040, 1'b0, 64'h0, 1'b1, "alloc");
    cnt_is(32'd1, "alloc");
    look(64'h1000, 1'b1, 1'b1, 64'h1040, "alloc");

    upd(64'h1000, 1'b1, 64'h1040, 1'b1, 64'h1040, 1'b0, "t1");
    upd(64'h1000, 1'b1, 64'h1040, 1'b1, 64'h1040, 1'b0, "t2");
    upd(64'h1000, 1'b1, 64'h1040, 1'b1, 64'h1040, 1'b0, "t3");
    cnt_is(32'd1, "t3");
    look(64'h1000, 1'b1, 1'b1, 64'h1040, "t3");
    upd(64'h1000, 1'b0, 64'h1002, 1'b1, 64'h1040, 1'b1, "nt1");
    look(64'h1000, 1'b1, 1'b1, 64'h1040, "nt1");
    upd(64'h1000, 1'b0, 64'h1002, 1'b1, 64'h1040, 1'b1, "nt2");
    look(64'h1000, 1'b1, 1'b0, 64'h1040, "nt2");
    cnt_is(32'd3, "nt2");

    look(64'h1080, 1'b0, 1'b0, 64'h0, "alias_pre");
    upd(64'h1080, 1'b1, 64'h3000, 1'b0, 64'h0, 1'b1, "alias");
    look(64'h1080, 1'b1, 1'b1, 64'h3000, "alias_new");
    look(64'h1000, 1'b0, 1'b0, 64'h0, "alias_old");
    cnt_is(32'd4, "alias");

    upd(64'h1080, 1'b1, 64'h2004, 1'b1, 64'h2000, 1'b1, "tgt");
    look(64'h1081, 1'b1, 1'b1, 64'h2004, "tgt_odd");
    cnt_is(32'd5, "tgt");

    upd(64'h5000, 1'b0, 64'h5100, 1'b0, 64'h0, 1'b0, "miss_nt");
    look(64'h5000, 1'b0, 1'b0, 64'h0, "miss_nt");
    look(64'h1080, 1'b1, 1'b1, 64'h2004, "miss_nt_keep");
    cnt_is(32'd5, "miss_nt");

    @(negedge clk);
    upd_pc = 64'h1080;
    upd_taken = 1'b1;
    upd_target = 64'h7777;
    upd_pred_taken = 1'b0;
    upd_pred_target = 64'h0;
    @(posedge clk);
    #1;
    look(64'h1080, 1'b1, 1'b1, 64'h2004, "idle");
    cnt_is(32'd5, "idle");

    pc_if = 64'h1080;
    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = 64'h1080;
    upd_taken = 1'b1;
    upd_target = 64'h2100;
    upd_pred_taken = 1'b1;
    upd_pred_target = 64'h2004;
    #1;
    chk("same.old_target", ptarget, 64'h2004);
    chk("same.mispredict", {63'd0, mispredict}, 64'd1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    look(64'h1080, 1'b1, 1'b1, 64'h2100, "same_new");
    cnt_is(32'd6, "same");

    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = 64'h1000;
    upd_taken = 1'b1;
    upd_target = 64'h9000;
    upd_pred_taken = 1'b1;
    upd_pred_target = 64'h9000;
    #2;
    rst_n = 1'b0;
    #1;
    look(64'h1080, 1'b0, 1'b0, 64'h0, "midrst");
    cnt_is(32'd0, "midrst");
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    look(64'h1000, 1'b0, 1'b0, 64'h0, "midrst_lost");
    cnt_is(32'd0, "midrst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
